// File: rtl/prores_patch_pkg.sv
// Shared types for the size back-patching block: scheduler states, queued slice
// results and the per-record patch byte counts.
package prores_patch_pkg;

    localparam int SLICE_PATCH_BYTES = 6;
    localparam int FRAME_PATCH_BYTES = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SLICE = 2'd1,
        ST_FRAME = 2'd2,
        ST_DONE  = 2'd3
    } patch_state_e;

    // idx is carried at full address width so the table offset needs no resizing
    typedef struct packed {
        logic [31:0] idx;
        logic [31:0] start_addr;
        logic [15:0] slice_size;
        logic [15:0] y_size;
        logic [15:0] cb_size;
    } slice_entry_t;

    // Big-endian byte lane of a 32-bit word: sel 0 is the most significant byte.
    function automatic logic [7:0] be_byte(input logic [31:0] word, input logic [1:0] sel);
        logic [31:0] shifted;
        shifted = word >> (5'd24 - {sel, 3'b000});
        return shifted[7:0];
    endfunction

endpackage

// File: rtl/patch_fifo.sv
// Synchronous FIFO with occupancy count; holds pending slice patch records.
module patch_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             clear,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic [CW-1:0]    count,
    output logic             empty
);

    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign w_do_push = push && (r_count != FULL_CNT);
    assign w_do_pop  = pop && (r_count != '0);

    always_ff @(posedge clock) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign pop_data = r_mem[r_rd_ptr];
    assign count    = r_count;
    assign empty    = (r_count == '0);

endmodule

// File: rtl/size_patch_scheduler.sv
// Back-patches slice table entries, slice header Y/Cb sizes and frame/picture sizes
// into the output buffer, yielding the shared write port to the live bitstream writer.
module size_patch_scheduler
    import prores_patch_pkg::*;
#(
    parameter int FIFO_DEPTH = 8,
    parameter int IDX_W      = 16
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        frame_start,
    input  logic [31:0] slice_size_offset_addr,
    input  logic [31:0] picture_size_offset_addr,
    input  logic [31:0] frame_size_offset_addr,
    input  logic [31:0] y_size_offset_addr,
    input  logic [31:0] cb_size_offset_addr,
    input  logic        slice_valid,
    output logic        slice_ready,
    input  logic [31:0] slice_start_addr,
    input  logic [15:0] slice_byte_size,
    input  logic [15:0] y_byte_size,
    input  logic [15:0] cb_byte_size,
    input  logic        frame_end,
    input  logic [31:0] frame_byte_size,
    input  logic [31:0] picture_byte_size,
    input  logic        stream_wr_en,
    input  logic [31:0] stream_wr_addr,
    input  logic [7:0]  stream_wr_data,
    output logic        mem_wr_en,
    output logic [31:0] mem_wr_addr,
    output logic [7:0]  mem_wr_data,
    output logic        busy,
    output logic        frame_done
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW-1:0] DEPTH_CNT     = CW'(FIFO_DEPTH);
    localparam logic [2:0]    SLICE_LAST_BC = 3'(SLICE_PATCH_BYTES - 1);
    localparam logic [2:0]    FRAME_LAST_BC = 3'(FRAME_PATCH_BYTES - 1);

    patch_state_e r_state;
    logic [2:0]   r_bc;
    slice_entry_t r_cur;
    logic         r_busy;
    logic         r_pending;
    logic         r_frame_done;
    logic [IDX_W-1:0] r_idx;
    logic [31:0]  r_slice_tab;
    logic [31:0]  r_pic_off;
    logic [31:0]  r_frm_off;
    logic [31:0]  r_y_off;
    logic [31:0]  r_cb_off;
    logic [31:0]  r_frm_size;
    logic [31:0]  r_pic_size;
    logic         r_mem_wr_en;
    logic [31:0]  r_mem_wr_addr;
    logic [7:0]   r_mem_wr_data;

    slice_entry_t w_push_entry;
    slice_entry_t w_pop_entry;
    logic [CW-1:0] w_count;
    logic         w_empty;
    logic         w_push;
    logic         w_pop;
    logic         w_clear;
    logic         w_emit;
    logic         w_last;
    logic [31:0]  w_patch_addr;
    logic [7:0]   w_patch_data;
    logic [31:0]  w_base;
    logic [15:0]  w_field;

    // Ready is taken from the registered count so a same-cycle pop never widens it.
    assign slice_ready = r_busy && (w_count < DEPTH_CNT);
    assign w_push      = slice_valid && slice_ready;
    assign w_pop       = (r_state == ST_IDLE) && !w_empty;
    assign w_clear     = (r_state == ST_DONE);

    always_comb begin
        w_push_entry            = '0;
        w_push_entry.idx        = 32'(r_idx);
        w_push_entry.start_addr = slice_start_addr;
        w_push_entry.slice_size = slice_byte_size;
        w_push_entry.y_size     = y_byte_size;
        w_push_entry.cb_size    = cb_byte_size;
    end

    patch_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH ($bits(slice_entry_t))
    ) u_patch_fifo (
        .clock     (clock),
        .reset_n   (reset_n),
        .clear     (w_clear),
        .push      (w_push),
        .push_data (w_push_entry),
        .pop       (w_pop),
        .pop_data  (w_pop_entry),
        .count     (w_count),
        .empty     (w_empty)
    );

    // The live writer always wins the port; the patch byte simply waits with bc held.
    assign w_emit = ((r_state == ST_SLICE) || (r_state == ST_FRAME)) && !stream_wr_en;
    assign w_last = ((r_state == ST_SLICE) && (r_bc == SLICE_LAST_BC))
                 || ((r_state == ST_FRAME) && (r_bc == FRAME_LAST_BC));

    always_comb begin
        w_patch_addr = '0;
        w_patch_data = '0;
        w_base       = '0;
        w_field      = '0;
        case (r_state)
            ST_SLICE: begin
                case (r_bc[2:1])
                    2'd0: begin
                        w_field = r_cur.slice_size;
                        w_base  = r_slice_tab + (r_cur.idx << 1);
                    end
                    2'd1: begin
                        w_field = r_cur.y_size;
                        w_base  = r_cur.start_addr + r_y_off;
                    end
                    default: begin
                        w_field = r_cur.cb_size;
                        w_base  = r_cur.start_addr + r_cb_off;
                    end
                endcase
                w_patch_addr = w_base + {31'd0, r_bc[0]};
                w_patch_data = r_bc[0] ? w_field[7:0] : w_field[15:8];
            end
            ST_FRAME: begin
                w_patch_addr = (r_bc[2] ? r_pic_off : r_frm_off) + {30'd0, r_bc[1:0]};
                w_patch_data = be_byte(r_bc[2] ? r_pic_size : r_frm_size, r_bc[1:0]);
            end
            default: begin
                w_patch_addr = '0;
                w_patch_data = '0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= ST_IDLE;
            r_bc          <= '0;
            r_cur         <= '0;
            r_busy        <= 1'b0;
            r_pending     <= 1'b0;
            r_frame_done  <= 1'b0;
            r_idx         <= '0;
            r_slice_tab   <= '0;
            r_pic_off     <= '0;
            r_frm_off     <= '0;
            r_y_off       <= '0;
            r_cb_off      <= '0;
            r_frm_size    <= '0;
            r_pic_size    <= '0;
            r_mem_wr_en   <= 1'b0;
            r_mem_wr_addr <= '0;
            r_mem_wr_data <= '0;
        end else begin
            r_frame_done <= 1'b0;

            if (stream_wr_en) begin
                r_mem_wr_en   <= 1'b1;
                r_mem_wr_addr <= stream_wr_addr;
                r_mem_wr_data <= stream_wr_data;
            end else if (w_emit) begin
                r_mem_wr_en   <= 1'b1;
                r_mem_wr_addr <= w_patch_addr;
                r_mem_wr_data <= w_patch_data;
            end else begin
                r_mem_wr_en   <= 1'b0;
            end

            if (frame_start && !r_busy) begin
                r_busy      <= 1'b1;
                r_idx       <= '0;
                r_slice_tab <= slice_size_offset_addr;
                r_pic_off   <= picture_size_offset_addr;
                r_frm_off   <= frame_size_offset_addr;
                r_y_off     <= y_size_offset_addr;
                r_cb_off    <= cb_size_offset_addr;
            end else if (w_push) begin
                r_idx <= r_idx + 1'b1;
            end

            if (frame_end && r_busy && !r_pending) begin
                r_pending  <= 1'b1;
                r_frm_size <= frame_byte_size;
                r_pic_size <= picture_byte_size;
            end

            case (r_state)
                ST_IDLE: begin
                    if (!w_empty) begin
                        r_cur   <= w_pop_entry;
                        r_bc    <= '0;
                        r_state <= ST_SLICE;
                    end else if (r_pending) begin
                        r_bc    <= '0;
                        r_state <= ST_FRAME;
                    end
                end
                ST_SLICE, ST_FRAME: begin
                    if (w_emit) begin
                        if (w_last) begin
                            r_state <= (r_state == ST_SLICE) ? ST_IDLE : ST_DONE;
                        end else begin
                            r_bc <= r_bc + 1'b1;
                        end
                    end
                end
                default: begin
                    r_frame_done <= 1'b1;
                    r_busy       <= 1'b0;
                    r_pending    <= 1'b0;
                    r_state      <= ST_IDLE;
                end
            endcase
        end
    end

    assign mem_wr_en   = r_mem_wr_en;
    assign mem_wr_addr = r_mem_wr_addr;
    assign mem_wr_data = r_mem_wr_data;
    assign busy        = r_busy;
    assign frame_done  = r_frame_done;

endmodule
